// File: rtl/hilo_muldiv_ctrl_if.sv
// Issue / result port bundle between the decode pipe and the mul/div sequencer.
interface hilo_muldiv_ctrl_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            flush;
   logic            hilo_access;
   logic            busy;
   logic            stall;
   logic            hilo_we;
   logic [XLEN-1:0] hi_out;
   logic [XLEN-1:0] lo_out;
   logic            done;
   logic            div_zero;

   modport master (
      output start, op, a, b, flush, hilo_access,
      input  busy, stall, hilo_we, hi_out, lo_out, done, div_zero
   );

   modport slave (
      input  start, op, a, b, flush, hilo_access,
      output busy, stall, hilo_we, hi_out, lo_out, done, div_zero
   );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer feeding the HI/LO write port.
// Operands are reduced to magnitudes at issue, iterated one bit per cycle,
// and the sign fix-up is folded into the final CALC cycle.
module hilo_muldiv_ctrl #(
   parameter int XLEN = 32
) (
   input logic               clk,
   input logic               rst,
   hilo_muldiv_ctrl_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic              is_div, sa, sb, dz;
   logic [XLEN-1:0]   a_r, mag_a, mag_b, quo, rem;
   logic [2*XLEN-1:0] prod;

   // issue-time operand conditioning
   logic              sgn_op, sa_in, sb_in;
   logic [XLEN-1:0]   mag_a_in, mag_b_in;

   assign sgn_op   = ~bus.op[0];
   assign sa_in    = sgn_op & bus.a[XLEN-1];
   assign sb_in    = sgn_op & bus.b[XLEN-1];
   assign mag_a_in = sa_in ? -bus.a : bus.a;
   assign mag_b_in = sb_in ? -bus.b : bus.b;

   // one shift-add step: multiplier rides in the low half of prod, LSB-first
   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] prod_nx;

   assign add_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
   assign prod_nx = {add_sum, prod[XLEN-1:1]};

   // one restoring-divide step: dividend bits shift out of quo MSB-first.
   // rem_sh fits in 33 bits; when rem_sh >= mag_b the 33-bit difference is
   // below mag_b so its top bit is clear, otherwise it wraps negative.
   logic [XLEN:0]     rem_sh, rem_sub;
   logic              rem_ge;
   logic [XLEN-1:0]   rem_nx, quo_nx;

   assign rem_sh  = {rem, quo[XLEN-1]};
   assign rem_sub = rem_sh - {1'b0, mag_b};
   assign rem_ge  = ~rem_sub[XLEN];
   assign rem_nx  = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign quo_nx  = {quo[XLEN-2:0], rem_ge};

   // sign fix-up on the final step's results (truncation toward zero)
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s;

   assign prod_s = (sa ^ sb) ? -prod_nx : prod_nx;
   assign quo_s  = (sa ^ sb) ? -quo_nx  : quo_nx;
   assign rem_s  = sa ? -rem_nx : rem_nx;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state: flush only matters in CALC; DONE always commits
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.start) state_nx = CALC;
         CALC: begin
            if (bus.flush)        state_nx = IDLE;
            else if (cnt == LAST) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // datapath: latch on issue, iterate in CALC, load result on the last step
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         is_div      <= 1'b0;
         sa          <= 1'b0;
         sb          <= 1'b0;
         dz          <= 1'b0;
         a_r         <= '0;
         mag_a       <= '0;
         mag_b       <= '0;
         quo         <= '0;
         rem         <= '0;
         prod        <= '0;
         bus.hi_out  <= '0;
         bus.lo_out  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               cnt    <= '0;
               is_div <= bus.op[1];
               sa     <= sa_in;
               sb     <= sb_in;
               dz     <= bus.op[1] & (bus.b == '0);
               a_r    <= bus.a;
               mag_a  <= mag_a_in;
               mag_b  <= mag_b_in;
               quo    <= mag_a_in;
               rem    <= '0;
               prod   <= {{XLEN{1'b0}}, mag_b_in};
            end
            CALC: if (!bus.flush) begin
               cnt  <= cnt + 1'b1;
               prod <= prod_nx;
               quo  <= quo_nx;
               rem  <= rem_nx;
               if (cnt == LAST) begin
                  if (!is_div) begin
                     {bus.hi_out, bus.lo_out} <= prod_s;
                  end else if (dz) begin
                     bus.hi_out <= a_r;
                     bus.lo_out <= '1;
                  end else begin
                     bus.hi_out <= rem_s;
                     bus.lo_out <= quo_s;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.stall    = bus.busy & bus.hilo_access;
   assign bus.hilo_we  = (state == DONE);
   assign bus.done     = (state == DONE);
   assign bus.div_zero = (state == DONE) & dz;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for the HI/LO mul/div sequencer.
module tb_hilo_muldiv_ctrl;
   logic clk;
   logic rst;
   int   total, passed, failed;

   hilo_muldiv_ctrl_if #(.XLEN(32)) bus ();

   hilo_muldiv_ctrl #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, follow it to DONE, check per-cycle busy/stall and the result.
   // poke re-issues garbage operands mid-CALC, which must be ignored.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz,
                         input logic access, input logic poke);
      int lat;
      lat = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      bus.hilo_access = access;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (poke && c == 5) begin
            bus.start = 1'b1; bus.op = ~op; bus.a = ~a; bus.b = b + 32'd3;
         end
         if (poke && c == 6) bus.start = 1'b0;
         if (bus.hilo_we) begin
            lat = c;
            break;
         end
         chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
         chk({tag, "_stall"}, 64'(bus.stall), 64'(access));
         chk({tag, "_dz_early"}, 64'(bus.div_zero), 64'(0));
         @(negedge clk);
      end
      chk({tag, "_lat"}, 64'(lat), 64'(33));
      chk({tag, "_done"}, 64'(bus.done), 64'(1));
      chk({tag, "_hi"}, 64'(bus.hi_out), 64'(exp_hi));
      chk({tag, "_lo"}, 64'(bus.lo_out), 64'(exp_lo));
      chk({tag, "_dz"}, 64'(bus.div_zero), 64'(exp_dz));
      chk({tag, "_stall_done"}, 64'(bus.stall), 64'(access));
      @(negedge clk);
      chk({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
      chk({tag, "_idle_we"}, 64'(bus.hilo_we), 64'(0));
      chk({tag, "_idle_dz"}, 64'(bus.div_zero), 64'(0));
      chk({tag, "_idle_stall"}, 64'(bus.stall), 64'(0));
      chk({tag, "_hold"}, {bus.hi_out, bus.lo_out}, {exp_hi, exp_lo});
      bus.hilo_access = 1'b0;
   endtask

   initial begin
      int wr;
      total = 0; passed = 0; failed = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.flush = 1'b0; bus.hilo_access = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_stall", 64'(bus.stall), 64'(0));
      chk("rst_we", 64'(bus.hilo_we), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_dz", 64'(bus.div_zero), 64'(0));
      chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'(0));
      rst = 1'b0;
      bus.hilo_access = 1'b0;

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
      run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b1);
      run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      run_op("div_nd",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0);
      run_op("div_dn",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
      run_op("divu",      2'b11, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
      run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      run_op("div_z",     2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      run_op("divu_z",    2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);

      // start with flush in the same IDLE cycle is accepted; flush in CALC aborts
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush_accept", 64'(bus.busy), 64'(1));
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_busy", 64'(bus.busy), 64'(0));
      chk("flush_we", 64'(bus.hilo_we), 64'(0));
      chk("flush_hold", {bus.hi_out, bus.lo_out}, {32'h1234_5678, 32'hFFFF_FFFF});
      run_op("after_flush", 2'b01, 32'd5, 32'd6, 32'h0000_0000, 32'h0000_001E, 1'b0, 1'b0, 1'b0);

      // synchronous reset mid-CALC: everything back to reset values, no write
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2;
      bus.hilo_access = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", 64'(bus.busy), 64'(0));
      chk("mid_rst_stall", 64'(bus.stall), 64'(0));
      chk("mid_rst_we", 64'(bus.hilo_we), 64'(0));
      chk("mid_rst_dz", 64'(bus.div_zero), 64'(0));
      chk("mid_rst_hilo", {bus.hi_out, bus.lo_out}, 64'(0));
      wr = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.hilo_we) wr++;
      end
      chk("mid_rst_nowrite", 64'(wr), 64'(0));
      bus.hilo_access = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
